product_accumulator: RTL
========================

// Module: product_accumulator
// PURPOSE
//  Downstream stage of the registered 32x32 multiplier. Takes the 64-bit
//  unsigned product stream and sums BATCH products into a wide accumulator.
//  Emits one batch sum per BATCH accepted products over a valid/ready
//  handshake. Gives the multiplier datapath a dot-product / MAC capability.
// PARAMETERS
//  PROD_W  64  width of incoming product
//  ACC_W   72  accumulator/output width (PROD_W + 8 guard bits); must be >= PROD_W
//  BATCH   16  products per emitted sum; must be >= 1
//  CNT_W   $clog2(BATCH+1)  width of the batch counter and the out_count port
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high reset
//  in_prod    in   PROD_W product from the multiplier output register (unsigned)
//  in_valid   in   1      in_prod is valid this cycle
//  in_ready   out  1      stage accepts in_prod this cycle
//  clear      in   1      synchronous discard of the partial batch
//  out_sum    out  ACC_W  batch sum
//  out_count  out  CNT_W  products in out_sum (always BATCH)
//  out_ovf    out  1      batch sum overflowed ACC_W
//  out_valid  out  1      out_sum/out_ovf valid
//  out_ready  in   1      consumer takes out_sum this cycle
// BEHAVIOUR
//  Reset (async, immediate): state=ACCUM, acc=0, cnt=0, ovf=0,
//   out_sum=0, out_count=0, out_ovf=0, out_valid=0. in_ready=1 once reset is low.
//  Mid-batch reset discards the partial sum and any held output.
//  Accept = in_valid & in_ready. Output xfer = out_valid & out_ready.
//  FSM, 2 states:
//   ACCUM: in_ready=1, out_valid=0.
//    - accept, cnt<BATCH-1: acc+=in_prod (zero-ext), cnt+=1.
//    - accept, cnt==BATCH-1: out_sum<=acc+in_prod, out_ovf<=ovf|carry,
//      out_count<=BATCH, out_valid<=1, acc<=0, cnt<=0, ovf<=0 -> HOLD.
//    - clear without accept: acc=0, cnt=0, ovf=0.
//    - clear with accept: the accepted product starts a new batch:
//      acc=in_prod, cnt=1, ovf=0. If BATCH==1 it emits directly.
//   HOLD: in_ready=0. out_sum, out_count, out_ovf and out_valid stay stable until xfer.
//    - xfer: out_valid<=0 -> ACCUM. No new accept in this same cycle.
//    - clear in HOLD is ignored; a held result is never dropped.
//  Latency: the last accepted product appears in out_sum on the next cycle.
//   Throughput: BATCH accepts plus at least 1 HOLD cycle per batch.
//  Arithmetic: unsigned. The add is computed ACC_W+1 wide. Bit ACC_W is the carry.
//  Overflow: ovf is sticky within a batch and reported on out_ovf with the sum.
//  in_valid may be dropped freely (no ordering requirement on the producer).
//   Unaccepted in_prod is not consumed.
//  BATCH==1: every accept goes ACCUM->HOLD. out_sum=in_prod, out_ovf=0
//   (ACC_W >= PROD_W).
// CONFIGURATION
//  PRODACC_SATURATE_EN
//   defined: on carry, acc clamps to 2^ACC_W-1 and stays clamped for the
//    rest of the batch; out_ovf=1.
//   undefined: sum wraps modulo 2^ACC_W; out_ovf=1; bits above the wrap are lost.
// TESTING
//  1 Reset: assert reset mid-batch (cnt=5) -> next cycle all outputs 0,
//    in_ready=1. The next batch sums only new products.
//  2 BATCH=4, products 1,2,3,4 with back-to-back valid, out_ready=1 ->
//    out_sum=10, out_count=4, out_ovf=0. in_ready low for exactly 1 cycle.
//  3 Backpressure: out_ready=0 for 10 cycles after emit -> out_sum held stable,
//    in_ready=0, no products lost. Next batch 5,5,5,5 -> 20.
//  4 Clear: products 7,7 then clear with accept of 9, then 1,1,1 -> out_sum=12.
//    Clear while in HOLD -> held sum is still delivered.
//  5 Overflow, ACC_W=64, BATCH=2: products 2^64-1 and 2 ->
//    wrap build: out_sum=1, out_ovf=1; SATURATE build: out_sum=2^64-1, out_ovf=1.
//  6 Random in_valid/out_ready (~50%), 1000 batches against a scoreboard model.
//    No lost or duplicated products. out_valid never drops without a xfer.

Source files
------------

// File: rtl/product_accumulator.sv
// ----------------------------------------------------------------------------
// product_accumulator
//
// Purpose:
//   This stage sits after the registered 32x32 multiplier. It adds BATCH
//   unsigned products into a wide accumulator. For each completed batch it
//   emits one sum over a valid/ready handshake, which gives the multiplier
//   datapath a dot-product / MAC capability.
//
// Configuration macro:
//   PRODACC_SATURATE_EN
//     defined   : on a carry out of ACC_W the accumulator clamps to
//                 2^ACC_W-1 and stays clamped for the rest of the batch.
//     undefined : the sum wraps modulo 2^ACC_W.
//   In both builds out_ovf reports the overflow with the batch sum.
//
// Ports:
//   clk        in   1       rising-edge clock
//   reset      in   1       asynchronous, active-high reset
//   in_prod    in   PROD_W  unsigned product from the multiplier
//   in_valid   in   1       in_prod is valid this cycle
//   in_ready   out  1       stage accepts in_prod this cycle
//   clear      in   1       synchronous discard of the partial batch
//   out_sum    out  ACC_W   batch sum
//   out_count  out  CNT_W   number of products in out_sum (always BATCH)
//   out_ovf    out  1       batch sum overflowed ACC_W
//   out_valid  out  1       out_sum/out_count/out_ovf are valid
//   out_ready  in   1       consumer takes out_sum this cycle
// ----------------------------------------------------------------------------
module product_accumulator #(
    parameter int PROD_W = 64,
    parameter int ACC_W  = 72,
    parameter int BATCH  = 16,
    parameter int CNT_W  = $clog2(BATCH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              clear,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LP_LAST  = CNT_W'(BATCH - 1);
    localparam logic [CNT_W-1:0] LP_BATCH = CNT_W'(BATCH);
    localparam logic [ACC_W-1:0] LP_MAX   = {ACC_W{1'b1}};

    state_t            r_state;
    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ovf;
    logic              r_in_ready;
    logic [ACC_W-1:0]  r_out_sum;
    logic [CNT_W-1:0]  r_out_count;
    logic              r_out_ovf;
    logic              r_out_valid;

    logic              w_accept;
    logic              w_xfer;
    logic [ACC_W-1:0]  w_base_acc;
    logic [CNT_W-1:0]  w_base_cnt;
    logic              w_base_ovf;
    logic [ACC_W:0]    w_prod_ext;
    logic [ACC_W:0]    w_sum;
    logic              w_carry;
    logic [ACC_W-1:0]  w_next_acc;
    logic              w_next_ovf;
    logic              w_last;

    assign w_accept = in_valid & r_in_ready;
    assign w_xfer   = r_out_valid & out_ready;

    // A clear that arrives together with an accept starts a new batch that
    // holds only this product, so the add is based on zero, not on the old acc.
    assign w_base_acc = clear ? {ACC_W{1'b0}} : r_acc;
    assign w_base_cnt = clear ? {CNT_W{1'b0}} : r_cnt;
    assign w_base_ovf = clear ? 1'b0 : r_ovf;

    // The add is one bit wider than ACC_W. Its top bit is the carry.
    assign w_prod_ext = {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
    assign w_sum      = {1'b0, w_base_acc} + w_prod_ext;
    assign w_carry    = w_sum[ACC_W];

`ifdef PRODACC_SATURATE_EN
    // Once clamped, every later add carries again or adds zero, so the
    // accumulator stays at the maximum until the batch ends.
    assign w_next_acc = w_carry ? LP_MAX : w_sum[ACC_W-1:0];
`else
    assign w_next_acc = w_sum[ACC_W-1:0];
`endif

    assign w_next_ovf = w_base_ovf | w_carry;
    assign w_last     = (w_base_cnt == LP_LAST);

    // Control FSM with the accumulator datapath and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_ACCUM;
            r_acc       <= {ACC_W{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_sum   <= {ACC_W{1'b0}};
            r_out_count <= {CNT_W{1'b0}};
            r_out_ovf   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_out_sum   <= w_next_acc;
                            r_out_ovf   <= w_next_ovf;
                            r_out_count <= LP_BATCH;
                            r_out_valid <= 1'b1;
                            r_acc       <= {ACC_W{1'b0}};
                            r_cnt       <= {CNT_W{1'b0}};
                            r_ovf       <= 1'b0;
                            r_in_ready  <= 1'b0;
                            r_state     <= ST_HOLD;
                        end else begin
                            r_acc <= w_next_acc;
                            r_cnt <= w_base_cnt + CNT_W'(1);
                            r_ovf <= w_next_ovf;
                        end
                    end else if (clear) begin
                        r_acc <= {ACC_W{1'b0}};
                        r_cnt <= {CNT_W{1'b0}};
                        r_ovf <= 1'b0;
                    end else begin
                        r_acc <= r_acc;
                    end
                end
                ST_HOLD: begin
                    // clear is ignored here so that a held result is never dropped.
                    if (w_xfer) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_ACCUM;
                    end else begin
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_ACCUM;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_sum   = r_out_sum;
    assign out_count = r_out_count;
    assign out_ovf   = r_out_ovf;
    assign out_valid = r_out_valid;

endmodule
